wb_weight_loader: RTL and testbench

Wishbone initiator that streams 8-bit synaptic weights from a valid/ready byte source into the SNN weight SRAM through the SNN Wishbone slave port. After a start pulse it issues one single-beat write per weight, for indices 0 to WEIGHTS-1. It sits between the weight source (a host-fed FIFO or a decompressor) and the `snn` slave on the user-area Wishbone bus. It reports busy, completion, error and progress status for the logic analyzer and IRQ.

---
 rtl/wb_weight_loader.sv | 118 +++++++++++
 tb/tb_wb_weight_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_weight_loader.sv
// Wishbone initiator that streams WEIGHTS bytes from a valid/ready source into
// the SNN weight-write register, one single-beat write per weight.
module wb_weight_loader #(
   parameter logic [31:0] TARGET_ADDR = 32'h3000_0000,
   parameter int          WEIGHTS     = 196,
   parameter int          TIMEOUT     = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        w_valid_i,
   input  logic [7:0]  w_data_i,
   output logic        w_ready_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [8:0]  count_o
);

   localparam int         TW       = $clog2(TIMEOUT + 1);
   localparam logic [7:0] LAST_IDX = 8'(WEIGHTS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, BUS, FINISH} state_t;

   state_t         state_q, state_d;
   logic           cyc_q;
   logic [7:0]     index_q;
   logic [8:0]     count_q;
   logic           err_q;
   logic [TW-1:0]  tmo_q;
   logic [31:0]    dat_q;
   logic           take_byte, tmo_hit, resp_err, resp_ack;

   // Source handshake: w_ready is high in FETCH; abort wins over a same-cycle byte.
   assign take_byte = (state_q == FETCH) && !abort_i && w_valid_i;
   assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
   // err beats ack; a late ack in the timeout cycle still counts as a response.
   assign resp_err  = (state_q == BUS) && (wbm_err_i || (!wbm_ack_i && tmo_hit));
   assign resp_ack  = (state_q == BUS) && wbm_ack_i && !wbm_err_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start_i) state_d = FETCH;
         FETCH: begin
            if (abort_i)        state_d = IDLE;
            else if (w_valid_i) state_d = BUS;
         end
         BUS: begin
            if (resp_err)                  state_d = FINISH;
            else if (resp_ack) begin
               if (index_q == LAST_IDX)    state_d = FINISH;
               else if (abort_i)           state_d = IDLE;
               else                        state_d = FETCH;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         index_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= (state_d == BUS);
         if (state_q == IDLE && start_i) begin
            index_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
         end
         if (take_byte) begin
            dat_q <= {16'h0, w_data_i, index_q};
            tmo_q <= '0;
         end
         if (state_q == BUS) begin
            if (resp_err) begin
               err_q <= 1'b1;
            end else if (resp_ack) begin
               count_q <= count_q + 9'd1;
               index_q <= index_q + 8'd1;
            end else begin
               tmo_q <= tmo_q + TW'(1);
            end
         end
      end
   end

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = cyc_q;
   assign wbm_sel_o = cyc_q ? 4'b0011 : 4'b0000;
   assign wbm_adr_o = cyc_q ? TARGET_ADDR : 32'h0;
   assign wbm_dat_o = dat_q;

   assign w_ready_o = (state_q == FETCH);
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == FINISH);
   assign err_o     = err_q;
   assign count_o   = count_q;

endmodule

// File: tb/tb_wb_weight_loader.sv
// Directed bench for wb_weight_loader with WEIGHTS=4, TIMEOUT=16; the bench
// plays both the byte source and the Wishbone slave.
module tb_wb_weight_loader;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        w_valid_i = 1'b0;
   logic [7:0]  w_data_i = 8'h0;
   logic        w_ready_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;
   logic        busy_o, done_o, err_o;
   logic [8:0]  count_o;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int t0, t1, tr;

   wb_weight_loader #(
      .TARGET_ADDR(32'h3000_0000),
      .WEIGHTS(4),
      .TIMEOUT(16)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .start_i(start_i), .abort_i(abort_i),
      .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .count_o(count_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
      cyc_n++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cyc"},   32'(wbm_cyc_o), 32'h0);
      chk({tag, "_stb"},   32'(wbm_stb_o), 32'h0);
      chk({tag, "_we"},    32'(wbm_we_o),  32'h0);
      chk({tag, "_sel"},   32'(wbm_sel_o), 32'h0);
      chk({tag, "_adr"},   wbm_adr_o,      32'h0);
      chk({tag, "_dat"},   wbm_dat_o,      32'h0);
      chk({tag, "_wrdy"},  32'(w_ready_o), 32'h0);
      chk({tag, "_busy"},  32'(busy_o),    32'h0);
      chk({tag, "_done"},  32'(done_o),    32'h0);
      chk({tag, "_err"},   32'(err_o),     32'h0);
      chk({tag, "_count"}, 32'(count_o),   32'h0);
   endtask

   task automatic do_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("start_busy", 32'(busy_o), 32'h1);
      chk("start_wrdy", 32'(w_ready_o), 32'h1);
   endtask

   // Offer a byte (optionally after a stall) and wait for the bus write it causes.
   task automatic offer(input logic [7:0] b, input logic [7:0] idx, input int stall,
                        output int t_rise);
      int n;
      w_valid_i = 1'b0;
      for (int s = 0; s < stall; s++) begin
         step();
         chk("stall_cyc", 32'(wbm_cyc_o), 32'h0);
         chk("stall_wrdy", 32'(w_ready_o), 32'h1);
      end
      w_valid_i = 1'b1;
      w_data_i  = b;
      n = 0;
      while (wbm_cyc_o !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      w_valid_i = 1'b0;
      t_rise = cyc_n;
      chk("wr_cyc", 32'(wbm_cyc_o), 32'h1);
      chk("wr_stb", 32'(wbm_stb_o), 32'h1);
      chk("wr_we",  32'(wbm_we_o),  32'h1);
      chk("wr_sel", 32'(wbm_sel_o), 32'h3);
      chk("wr_adr", wbm_adr_o, 32'h3000_0000);
      chk("wr_dat", wbm_dat_o, {16'h0, b, idx});
   endtask

   // Slave response dly cycles after stb rose, then check the cycle ends.
   task automatic respond(input int dly, input logic a, input logic e);
      for (int k = 0; k < dly; k++) begin
         step();
         chk("cyc_hold", 32'(wbm_cyc_o), 32'h1);
      end
      wbm_ack_i = a;
      wbm_err_i = e;
      step();
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      chk("cyc_drop", 32'(wbm_cyc_o), 32'h0);
      chk("sel_drop", 32'(wbm_sel_o), 32'h0);
      chk("adr_drop", wbm_adr_o, 32'h0);
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk_all_zero("rst");
      wb_rst_ni = 1'b1;
      step();

      // Full load, source always valid, ack one cycle after stb
      do_start();
      offer(8'h11, 8'd0, 0, t0); respond(1, 1'b1, 1'b0);
      chk("full_cnt1", 32'(count_o), 32'd1);
      chk("full_wrdy_after_ack", 32'(w_ready_o), 32'h1);
      offer(8'h22, 8'd1, 0, t1); respond(1, 1'b1, 1'b0);
      chk("throughput", 32'(t1 - t0), 32'd3);
      offer(8'h33, 8'd2, 0, tr); respond(1, 1'b1, 1'b0);
      offer(8'h44, 8'd3, 0, tr); respond(1, 1'b1, 1'b0);
      chk("full_done", 32'(done_o), 32'h1);
      chk("full_busy", 32'(busy_o), 32'h1);
      chk("full_count", 32'(count_o), 32'd4);
      chk("full_err", 32'(err_o), 32'h0);
      step();
      chk("full_done_end", 32'(done_o), 32'h0);
      chk("full_busy_end", 32'(busy_o), 32'h0);

      // Source stall before byte 2
      do_start();
      chk("stall_count_clr", 32'(count_o), 32'd0);
      offer(8'h11, 8'd0, 0, tr); respond(1, 1'b1, 1'b0);
      offer(8'h22, 8'd1, 5, tr); respond(1, 1'b1, 1'b0);
      offer(8'h33, 8'd2, 0, tr); respond(1, 1'b1, 1'b0);
      offer(8'h44, 8'd3, 0, tr); respond(1, 1'b1, 1'b0);
      chk("stall_done", 32'(done_o), 32'h1);
      chk("stall_count", 32'(count_o), 32'd4);
      step();

      // Timeout: slave never responds
      do_start();
      offer(8'h55, 8'd0, 0, tr);
      for (int k = 1; k < 16; k++) begin
         step();
         chk("tmo_stb_hold", 32'(wbm_stb_o), 32'h1);
      end
      step();
      chk("tmo_stb", 32'(wbm_stb_o), 32'h0);
      chk("tmo_err", 32'(err_o), 32'h1);
      chk("tmo_done", 32'(done_o), 32'h1);
      chk("tmo_count", 32'(count_o), 32'd0);
      step();
      chk("tmo_err_sticky", 32'(err_o), 32'h1);
      chk("tmo_idle", 32'(busy_o), 32'h0);
      do_start();
      chk("start_clears_err", 32'(err_o), 32'h0);

      // Abort in FETCH with a byte on offer: no bus cycle, no done
      abort_i   = 1'b1;
      w_valid_i = 1'b1;
      w_data_i  = 8'h66;
      step();
      abort_i = 1'b0;
      chk("fabort_busy", 32'(busy_o), 32'h0);
      chk("fabort_cyc", 32'(wbm_cyc_o), 32'h0);
      chk("fabort_done", 32'(done_o), 32'h0);
      step();
      chk("fabort_cyc2", 32'(wbm_cyc_o), 32'h0);
      chk("fabort_done2", 32'(done_o), 32'h0);
      w_valid_i = 1'b0;

      // Bus error together with ack on write 2
      do_start();
      offer(8'h77, 8'd0, 0, tr); respond(1, 1'b1, 1'b0);
      chk("berr_cnt1", 32'(count_o), 32'd1);
      offer(8'h88, 8'd1, 0, tr); respond(1, 1'b1, 1'b1);
      chk("berr_err", 32'(err_o), 32'h1);
      chk("berr_count", 32'(count_o), 32'd1);
      chk("berr_done", 32'(done_o), 32'h1);
      step();
      chk("berr_idle", 32'(busy_o), 32'h0);

      // Abort while in BUS, ack delayed 3 cycles
      do_start();
      offer(8'h99, 8'd0, 0, tr);
      abort_i = 1'b1;
      respond(3, 1'b1, 1'b0);
      chk("babort_busy", 32'(busy_o), 32'h0);
      chk("babort_done", 32'(done_o), 32'h0);
      chk("babort_count", 32'(count_o), 32'd1);
      abort_i = 1'b0;
      step();
      chk("babort_done2", 32'(done_o), 32'h0);

      // Asynchronous reset in the middle of a bus cycle
      do_start();
      offer(8'hAA, 8'd0, 0, tr);
      #2;
      wb_rst_ni = 1'b0;
      #1;
      chk_all_zero("arst");
      step();
      step();
      wb_rst_ni = 1'b1;
      step();

      // Start pulses during a load are ignored
      do_start();
      offer(8'hA1, 8'd0, 0, tr); respond(1, 1'b1, 1'b0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("ign_busy", 32'(busy_o), 32'h1);
      chk("ign_count", 32'(count_o), 32'd1);
      chk("ign_wrdy", 32'(w_ready_o), 32'h1);
      offer(8'hB2, 8'd1, 0, tr); respond(1, 1'b1, 1'b0);
      offer(8'hC3, 8'd2, 0, tr);
      start_i = 1'b1;
      respond(1, 1'b1, 1'b0);
      start_i = 1'b0;
      offer(8'hD4, 8'd3, 0, tr); respond(1, 1'b1, 1'b0);
      chk("ign_done", 32'(done_o), 32'h1);
      chk("ign_count4", 32'(count_o), 32'd4);
      step();
      chk("ign_idle", 32'(busy_o), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
